score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Upstream feeder for the 3-digit BCD score converter on the Pac-Man display path.
- Accumulates game events from the gameplay logic into a saturating 10-bit binary score, tracks lives and the session high score, and sequences the game between idle, play, death-freeze and game-over.
- `score` and `high_score` drive the BCD converters' `binary` inputs directly, so both never exceed 999.

Parameters:
- MAX_SCORE, 999, saturation ceiling; must be ≤ 999.
- PELLET_PTS, 1, points per pellet.
- POWER_PTS, 5, points per power pellet.
- GHOST_BASE, 20, points for the first ghost of a power period.
- START_LIVES, 3, lives loaded on game start (1–3).
- FREEZE_CYCLES, 8, length of the death freeze in clock cycles (≥ 1).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- game_start, input, 1, one-cycle pulse to begin a game.
- pellet_eaten, input, 1, one-cycle event pulse.
- power_eaten, input, 1, one-cycle event pulse.
- ghost_eaten, input, 1, one-cycle event pulse.
- pacman_caught, input, 1, one-cycle event pulse.
- score, output, 10, current score (binary, 0..MAX_SCORE).
- high_score, output, 10, best finished-game score since reset.
- lives, output, 2, remaining lives.
- playing, output, 1, high in PLAY.
- frozen, output, 1, high in DYING.
- game_over, output, 1, high in OVER.

Behaviour:
- All outputs are registered and update on the clock edge after the input event (latency 1).
- Sync reset is active-high, sampled on the clk edge. It forces state IDLE and clears `score`, `high_score`, `lives`, the combo counter and the freeze counter; `playing`, `frozen` and `game_over` are 0.
- A reset asserted in any state, including mid-freeze, takes priority over all other inputs.
- IDLE:
  - Event inputs are ignored.
  - `game_start` → PLAY: score=0, lives=START_LIVES, combo=0.
- PLAY, per cycle:
  - Points awarded = sum of all asserted events:
    - PELLET_PTS if `pellet_eaten`.
    - POWER_PTS if `power_eaten`.
    - GHOST_BASE << combo if `ghost_eaten`.
  - Ghost value: if `power_eaten` and `ghost_eaten` are in the same cycle, the ghost is scored with combo 0.
  - Score update: score ← min(score + points, MAX_SCORE). Compute in ≥ 12 bits so the sum never wraps.
  - Combo counter (2 bits, values 0..3, saturating):
    - cleared by `power_eaten`;
    - incremented by `ghost_eaten`, after any clear in the same cycle.
    - Ghost values are therefore 20/40/80/160, with 160 repeating.
  - `pacman_caught`:
    - Points from the same cycle are still awarded.
    - lives ← lives − 1, freeze counter ← FREEZE_CYCLES − 1, combo ← 0.
    - → DYING.
  - `game_start` is ignored in PLAY.
- DYING:
  - All event inputs and `game_start` are ignored.
  - The freeze counter decrements each cycle. When it reads 0:
    - lives = 0 → OVER;
    - otherwise → PLAY.
  - Dwell in DYING is exactly FREEZE_CYCLES cycles.
- OVER:
  - On entry, high_score ← max(high_score, score). Equal scores leave it unchanged.
  - `score` holds its final value.
  - `game_start` → PLAY with the same initialisation as from IDLE. `high_score` is retained.
- Boundary rules:
  - Score saturates at MAX_SCORE and never wraps.
  - `lives` never underflows.
  - The combo counter never exceeds 3.

Test Plan:
- Reset then `game_start`, then 3 `pellet_eaten` pulses → score 0→1→2→3 one cycle after each pulse; lives=3; playing=1.
- `power_eaten`, then 5 `ghost_eaten` pulses on separate cycles → score +5, +20, +40, +80, +160, +160 (total 465 from 0). A second `power_eaten` resets the combo, so the next ghost gives +20.
- Score 990, then `ghost_eaten` with combo 0 → score 999. A further `pellet_eaten` leaves it at 999.
- `pacman_caught` together with `pellet_eaten` at score 10 → score 11, lives 3→2, frozen=1 for exactly 8 cycles. `pellet_eaten` pulses during the freeze leave the score at 11; then playing=1.
- Three `pacman_caught` events with final score 250 → game_over=1, high_score=250. Restart, score 100, lose all lives → high_score stays 250.
- Reset asserted on freeze cycle 3 → next cycle: IDLE, all outputs 0 including high_score. `game_start` in the same cycle as reset has no effect.

Source files
------------

// File: rtl/score_keeper.sv
// Score, lives and high-score tracker feeding the BCD display converters.
// Sequences the game through IDLE, PLAY, DYING (freeze) and OVER.
module score_keeper #(
  parameter int MAX_SCORE     = 999,
  parameter int PELLET_PTS    = 1,
  parameter int POWER_PTS     = 5,
  parameter int GHOST_BASE    = 20,
  parameter int START_LIVES   = 3,
  parameter int FREEZE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_start,
  input  logic       pellet_eaten,
  input  logic       power_eaten,
  input  logic       ghost_eaten,
  input  logic       pacman_caught,
  output logic [9:0] score,
  output logic [9:0] high_score,
  output logic [1:0] lives,
  output logic       playing,
  output logic       frozen,
  output logic       game_over
);

  localparam int FW = (FREEZE_CYCLES > 1) ? $clog2(FREEZE_CYCLES) : 1;
  localparam logic [11:0]   MAX_W    = 12'(MAX_SCORE);
  localparam logic [11:0]   PELLET_W = 12'(PELLET_PTS);
  localparam logic [11:0]   POWER_W  = 12'(POWER_PTS);
  localparam logic [11:0]   GHOST_W  = 12'(GHOST_BASE);
  localparam logic [1:0]    LIVES_W  = 2'(START_LIVES);
  localparam logic [FW-1:0] FREEZE_W = FW'(FREEZE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t      state_r;
  logic [9:0]  score_r;
  logic [9:0]  high_score_r;
  logic [1:0]  lives_r;
  logic [1:0]  combo_r;
  logic [FW-1:0] freeze_r;
  logic        playing_r;
  logic        frozen_r;
  logic        game_over_r;

  logic [1:0]  combo_base_s;
  logic [1:0]  combo_next_s;
  logic [11:0] points_s;
  logic [11:0] sum_s;
  logic [9:0]  score_next_s;

  function automatic logic [9:0] max10(input logic [9:0] a, input logic [9:0] b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // Points and combo for this cycle; a power pellet restarts the combo before any ghost is valued.
  always_comb begin
    combo_base_s = combo_r;
    combo_next_s = combo_r;
    points_s     = 12'd0;
    sum_s        = 12'd0;
    score_next_s = score_r;
    if (power_eaten) begin
      combo_base_s = 2'd0;
    end else begin
      combo_base_s = combo_r;
    end
    combo_next_s = combo_base_s;
    if (pellet_eaten) begin
      points_s = points_s + PELLET_W;
    end else begin
      points_s = points_s;
    end
    if (power_eaten) begin
      points_s = points_s + POWER_W;
    end else begin
      points_s = points_s;
    end
    if (ghost_eaten) begin
      points_s = points_s + (GHOST_W << combo_base_s);
      if (combo_base_s != 2'd3) begin
        combo_next_s = combo_base_s + 2'd1;
      end else begin
        combo_next_s = combo_base_s;
      end
    end else begin
      combo_next_s = combo_base_s;
    end
    sum_s = {2'b00, score_r} + points_s;
    if (sum_s > MAX_W) begin
      score_next_s = MAX_W[9:0];
    end else begin
      score_next_s = sum_s[9:0];
    end
  end

  // Game sequencer with all state and outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      score_r      <= 10'd0;
      high_score_r <= 10'd0;
      lives_r      <= 2'd0;
      combo_r      <= 2'd0;
      freeze_r     <= {FW{1'b0}};
      playing_r    <= 1'b0;
      frozen_r     <= 1'b0;
      game_over_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, OVER: begin
          if (game_start) begin
            state_r     <= PLAY;
            score_r     <= 10'd0;
            lives_r     <= LIVES_W;
            combo_r     <= 2'd0;
            playing_r   <= 1'b1;
            game_over_r <= 1'b0;
          end
        end
        PLAY: begin
          score_r <= score_next_s;
          if (pacman_caught) begin
            lives_r   <= (lives_r == 2'd0) ? 2'd0 : lives_r - 2'd1;
            freeze_r  <= FREEZE_W;
            combo_r   <= 2'd0;
            state_r   <= DYING;
            playing_r <= 1'b0;
            frozen_r  <= 1'b1;
          end else begin
            combo_r <= combo_next_s;
          end
        end
        DYING: begin
          if (freeze_r == {FW{1'b0}}) begin
            frozen_r <= 1'b0;
            if (lives_r == 2'd0) begin
              state_r      <= OVER;
              game_over_r  <= 1'b1;
              high_score_r <= max10(high_score_r, score_r);
            end else begin
              state_r   <= PLAY;
              playing_r <= 1'b1;
            end
          end else begin
            freeze_r <= freeze_r - FW'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          playing_r   <= 1'b0;
          frozen_r    <= 1'b0;
          game_over_r <= 1'b0;
        end
      endcase
    end
  end

  assign score      = score_r;
  assign high_score = high_score_r;
  assign lives      = lives_r;
  assign playing    = playing_r;
  assign frozen     = frozen_r;
  assign game_over  = game_over_r;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus random events,
// compared every cycle against a behavioural game model.
module tb_score_keeper;

  logic       clk;
  logic       reset;
  logic       game_start;
  logic       pellet_eaten;
  logic       power_eaten;
  logic       ghost_eaten;
  logic       pacman_caught;
  logic [9:0] score;
  logic [9:0] high_score;
  logic [1:0] lives;
  logic       playing;
  logic       frozen;
  logic       game_over;

  int n_checks;
  int n_errors;

  // Reference game model
  int m_score, m_high, m_lives, m_ghosts, m_dwell;
  bit m_play, m_dying, m_over;

  score_keeper dut (
    .clk(clk), .reset(reset), .game_start(game_start),
    .pellet_eaten(pellet_eaten), .power_eaten(power_eaten),
    .ghost_eaten(ghost_eaten), .pacman_caught(pacman_caught),
    .score(score), .high_score(high_score), .lives(lives),
    .playing(playing), .frozen(frozen), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_step();
    int pts;
    if (reset) begin
      m_score = 0; m_high = 0; m_lives = 0; m_ghosts = 0; m_dwell = 0;
      m_play = 0; m_dying = 0; m_over = 0;
    end else if (m_play) begin
      pts = 0;
      if (pellet_eaten) pts += 1;
      if (power_eaten) begin
        pts += 5;
        m_ghosts = 0;
      end
      if (ghost_eaten) begin
        pts += 20 * (2 ** ((m_ghosts < 3) ? m_ghosts : 3));
        m_ghosts++;
      end
      m_score = (m_score + pts > 999) ? 999 : m_score + pts;
      if (pacman_caught) begin
        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        m_dwell = 0;
        m_ghosts = 0;
        m_play = 0;
        m_dying = 1;
      end
    end else if (m_dying) begin
      m_dwell++;
      if (m_dwell == 8) begin
        m_dying = 0;
        if (m_lives == 0) begin
          m_over = 1;
          if (m_score > m_high) m_high = m_score;
        end else begin
          m_play = 1;
        end
      end
    end else if (game_start) begin
      m_play = 1; m_over = 0; m_score = 0; m_lives = 3; m_ghosts = 0;
    end
  endtask

  task automatic tick(input bit p, input bit w, input bit g, input bit c, input bit s, input bit r);
    pellet_eaten = p; power_eaten = w; ghost_eaten = g;
    pacman_caught = c; game_start = s; reset = r;
    @(posedge clk);
    #1;
    model_step();
    check_val("score", 32'(score), 32'(m_score));
    check_val("high_score", 32'(high_score), 32'(m_high));
    check_val("lives", 32'(lives), 32'(m_lives));
    check_val("playing", 32'(playing), 32'(m_play));
    check_val("frozen", 32'(frozen), 32'(m_dying));
    check_val("game_over", 32'(game_over), 32'(m_over));
    pellet_eaten = 0; power_eaten = 0; ghost_eaten = 0;
    pacman_caught = 0; game_start = 0; reset = 0;
  endtask

  task automatic lose_life();
    tick(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int fcnt;
    n_checks = 0; n_errors = 0;
    m_score = 0; m_high = 0; m_lives = 0; m_ghosts = 0; m_dwell = 0;
    m_play = 0; m_dying = 0; m_over = 0;
    reset = 1; game_start = 0; pellet_eaten = 0; power_eaten = 0;
    ghost_eaten = 0; pacman_caught = 0;
    #1;
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    check_val("reset_score", 32'(score), 32'd0);
    tick(1, 0, 0, 0, 0, 0);
    check_val("idle_ignores_events", 32'(score), 32'd0);

    // Start and pellets
    tick(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0, 0);
    check_val("three_pellets", 32'(score), 32'd3);
    check_val("start_lives", 32'(lives), 32'd3);

    // Ghost combo chain
    tick(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 0, 0, 0);
    check_val("combo_total", 32'(score), 32'd468);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    check_val("combo_reset", 32'(score), 32'd493);
    tick(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 1, 0, 0, 0);
    check_val("second_chain", 32'(score), 32'd958);
    tick(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 27; i++) tick(1, 0, 0, 0, 0, 0);
    check_val("at_990", 32'(score), 32'd990);
    tick(0, 0, 1, 0, 0, 0);
    check_val("saturate_ghost", 32'(score), 32'd999);
    tick(1, 0, 0, 0, 0, 0);
    check_val("saturate_pellet", 32'(score), 32'd999);
    tick(0, 1, 1, 0, 0, 0);
    check_val("saturate_both", 32'(score), 32'd999);

    // Caught with pellet at score 10, freeze length
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    check_val("caught_score", 32'(score), 32'd11);
    check_val("caught_lives", 32'(lives), 32'd2);
    fcnt = int'(frozen);
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 0, 0, 1, 0);
      fcnt += int'(frozen);
    end
    check_val("freeze_len", 32'(fcnt), 32'd8);
    check_val("freeze_score", 32'(score), 32'd11);
    check_val("resume_play", 32'(playing), 32'd1);

    // Reach 250, lose remaining lives
    tick(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 29; i++) tick(1, 0, 0, 0, 0, 0);
    check_val("score_250", 32'(score), 32'd250);
    lose_life();
    lose_life();
    check_val("over_flag", 32'(game_over), 32'd1);
    check_val("high_250", 32'(high_score), 32'd250);
    tick(1, 1, 1, 1, 0, 0);
    check_val("over_hold", 32'(score), 32'd250);

    // Lower second game leaves high score
    tick(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 100; i++) tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) lose_life();
    check_val("high_kept", 32'(high_score), 32'd250);
    check_val("final_100", 32'(score), 32'd100);

    // Reset mid-freeze with a simultaneous start
    tick(0, 0, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 1);
    check_val("rst_high", 32'(high_score), 32'd0);
    check_val("rst_playing", 32'(playing), 32'd0);
    check_val("rst_frozen", 32'(frozen), 32'd0);

    // Random play
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(1, 0) == 1, $urandom_range(9, 0) == 0,
           $urandom_range(4, 0) == 0, $urandom_range(59, 0) == 0,
           $urandom_range(19, 0) == 0, $urandom_range(499, 0) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
